// File: rtl/pe_operand_sequencer.sv
// Operand sequencer for one PE: streams vectors A and B into the PE, runs the MAC, returns the dot product.
// Optional macro PE_SEQ_CHECK_EN enables the MAC_DONE length-mismatch check (sticky ERR).
module pe_operand_sequencer #(
  parameter int N  = 16,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [1:0]    DIMEN,
  output logic          BUSY,
  input  logic          SRC_VALID,
  input  logic [DW-1:0] SRC_DATA,
  output logic          SRC_READY,
  output logic          PE_RST_ADD,
  output logic [DW-1:0] PE_DATAIN,
  output logic          PE_MAT_MUX,
  output logic          PE_WRITE,
  output logic [1:0]    PE_DIMEN,
  output logic          PE_MAC_CTRL,
  output logic          PE_RST_ACC,
  output logic          PE_RST_PC,
  output logic          PE_OUT_RDY,
  input  logic          PE_MAC_DONE,
  input  logic [DW-1:0] PE_DATAOUT,
  output logic          RES_VALID,
  output logic [DW-1:0] RES_DATA,
  input  logic          RES_READY,
  output logic          DONE,
  output logic          ERR
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD_A, S_RADDR, S_LOAD_B, S_MAC, S_READ, S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dimen_q;
  logic [DW-1:0] res_q;
  logic [CW-1:0] len;
  logic [CW-1:0] last;
  logic          src_fire;

  // Vector length L = 2^(DIMEN+1)
  function automatic logic [CW-1:0] len_of(input logic [1:0] d);
    return CW'(2) << d;
  endfunction

  assign len       = len_of(dimen_q);
  assign last      = len - CW'(1);
  assign src_fire  = SRC_VALID & SRC_READY;
  assign PE_WRITE  = src_fire;
  assign PE_DATAIN = SRC_DATA;
  assign PE_DIMEN  = dimen_q;
  assign RES_DATA  = res_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dimen_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && START) dimen_q <= DIMEN;
    end
  end

  // Result capture: PE_DATAOUT is only meaningful during READ
  always_ff @(posedge CLK) begin
    if (RST)                  res_q <= '0;
    else if (state_q == S_READ) res_q <= PE_DATAOUT;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    BUSY        = (state_q != S_IDLE);
    SRC_READY   = 1'b0;
    PE_RST_ADD  = 1'b0;
    PE_MAT_MUX  = 1'b0;
    PE_MAC_CTRL = 1'b0;
    PE_RST_ACC  = 1'b0;
    PE_RST_PC   = 1'b0;
    PE_OUT_RDY  = 1'b0;
    RES_VALID   = 1'b0;
    DONE        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_CLR;
      end
      S_CLR: begin
        PE_RST_ADD = 1'b1;
        PE_RST_ACC = 1'b1;
        PE_RST_PC  = 1'b1;
        cnt_d      = '0;
        state_d    = S_LOAD_A;
      end
      S_LOAD_A: begin
        PE_MAT_MUX = 1'b1;
        SRC_READY  = (cnt_q < len);
        if (src_fire) begin
          if (cnt_q == last) begin
            cnt_d   = '0;
            state_d = S_RADDR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RADDR: begin
        PE_RST_ADD = 1'b1;
        cnt_d      = '0;
        state_d    = S_LOAD_B;
      end
      S_LOAD_B: begin
        SRC_READY = (cnt_q < len);
        if (src_fire) begin
          if (cnt_q == last) begin
            cnt_d   = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_MAC: begin
        PE_MAC_CTRL = 1'b1;
        if (cnt_q == last) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        PE_OUT_RDY = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        RES_VALID = 1'b1;
        if (RES_READY) begin
          DONE    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PE_SEQ_CHECK_EN
  logic err_q;

  // MAC_DONE must rise exactly on the last MAC cycle; any other pattern is sticky
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (state_q == S_MAC) begin
      if ((cnt_q == last) != PE_MAC_DONE) err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  logic unused_mac_done;
  assign unused_mac_done = PE_MAC_DONE;
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Scoreboard bench for pe_operand_sequencer with a behavioural PE model attached.
module tb_pe_operand_sequencer;
  localparam int N  = 16;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST, START, SRC_VALID, RES_READY;
  logic [1:0]    DIMEN;
  logic [DW-1:0] SRC_DATA;
  logic          BUSY, SRC_READY, PE_RST_ADD, PE_MAT_MUX, PE_WRITE;
  logic [DW-1:0] PE_DATAIN, PE_DATAOUT, RES_DATA;
  logic [1:0]    PE_DIMEN;
  logic          PE_MAC_CTRL, PE_RST_ACC, PE_RST_PC, PE_OUT_RDY, PE_MAC_DONE;
  logic          RES_VALID, DONE, ERR;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int write_cnt = 0;
  bit stable_bad = 0;
  bit force_bad = 0;
  logic [DW-1:0] words_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  pe_operand_sequencer #(.N(N), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIMEN(DIMEN), .BUSY(BUSY),
    .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_READY(SRC_READY),
    .PE_RST_ADD(PE_RST_ADD), .PE_DATAIN(PE_DATAIN), .PE_MAT_MUX(PE_MAT_MUX),
    .PE_WRITE(PE_WRITE), .PE_DIMEN(PE_DIMEN), .PE_MAC_CTRL(PE_MAC_CTRL),
    .PE_RST_ACC(PE_RST_ACC), .PE_RST_PC(PE_RST_PC), .PE_OUT_RDY(PE_OUT_RDY),
    .PE_MAC_DONE(PE_MAC_DONE), .PE_DATAOUT(PE_DATAOUT), .RES_VALID(RES_VALID),
    .RES_DATA(RES_DATA), .RES_READY(RES_READY), .DONE(DONE), .ERR(ERR)
  );

  // Behavioural PE: vector memories, write address, MAC program counter, accumulator
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];
  logic [4:0]    waddr, pc;
  logic [DW-1:0] acc;
  logic [4:0]    pe_len;

  assign pe_len      = 5'd2 << PE_DIMEN;
  assign PE_MAC_DONE = PE_MAC_CTRL && (pc == pe_len - 5'd1) && !force_bad;
  assign PE_DATAOUT  = PE_OUT_RDY ? acc : '0;

  always @(posedge CLK) begin
    if (PE_RST_ADD) waddr <= '0;
    else if (PE_WRITE) begin
      if (PE_MAT_MUX) mem_a[waddr[3:0]] <= PE_DATAIN;
      else            mem_b[waddr[3:0]] <= PE_DATAIN;
      waddr <= waddr + 5'd1;
    end
    if (PE_RST_ACC) acc <= '0;
    else if (PE_MAC_CTRL) acc <= acc + mem_a[pc[3:0]] * mem_b[pc[3:0]];
    if (PE_RST_PC) pc <= '0;
    else if (PE_MAC_CTRL) pc <= pc + 5'd1;
  end

  // Result monitor: pops the scoreboard on every result handshake
  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (PE_WRITE) write_cnt++;
    if (RES_VALID && RES_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got %0d, none expected", RES_DATA);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (RES_DATA !== e) begin
          errors++;
          $display("FAIL result_data: got %0d, expected %0d", RES_DATA, e);
        end
      end
      checks++;
      if (DONE !== 1'b1) begin
        errors++;
        $display("FAIL done_on_handshake: got %b, expected 1", DONE);
      end
    end
  end

  task automatic apply_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] dim, input bit gap, input int rr_hold,
                       input bit start_in_mac, input int abort_after, output int lat);
    int cyc, hold_seen, fires;
    bit phase, fin;
    logic [DW-1:0] held;
    cyc = 0; hold_seen = 0; fires = 0; phase = 0; fin = 0; held = '0; lat = -1;
    @(posedge CLK); #1;
    DIMEN = dim; START = 1'b1; RES_READY = (rr_hold == 0);
    @(posedge CLK); #1;
    START = 1'b0; DIMEN = ~dim; cyc = 1;
    while (!fin && cyc < 2000) begin
      if (words_q.size() > 0 && (!gap || phase)) begin
        SRC_VALID = 1'b1; SRC_DATA = words_q[0];
      end else begin
        SRC_VALID = 1'b0; SRC_DATA = $urandom;
      end
      phase = !phase;
      START = start_in_mac && PE_MAC_CTRL;
      #1;
      if (SRC_VALID && SRC_READY) begin
        void'(words_q.pop_front());
        fires++;
      end
      @(posedge CLK); #1;
      cyc++;
      if (abort_after > 0 && fires == abort_after) begin
        RST = 1'b1; SRC_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        words_q.delete();
        fin = 1;
      end else if (RES_VALID) begin
        if (lat < 0) begin
          lat = cyc; held = RES_DATA;
        end else if (RES_DATA !== held) begin
          stable_bad = 1;
        end
        hold_seen++;
        if (hold_seen > rr_hold) RES_READY = 1'b1;
      end else if (!BUSY) begin
        fin = 1;
      end
    end
    SRC_VALID = 1'b0; START = 1'b0; RES_READY = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL op_timeout: got %0d cycles, expected completion", cyc);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({BUSY, SRC_READY, PE_RST_ADD, PE_MAT_MUX, PE_WRITE, PE_MAC_CTRL,
         PE_RST_ACC, PE_RST_PC, PE_OUT_RDY, RES_VALID, DONE} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got BUSY=%b SRC_READY=%b RES_VALID=%b DONE=%b, expected all 0",
               BUSY, SRC_READY, RES_VALID, DONE);
    end
    checks++;
    if (RES_DATA !== '0) begin
      errors++; $display("FAIL reset_res_data: got %0d, expected 0", RES_DATA);
    end
    checks++;
    if (ERR !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b, expected 0", ERR);
    end
    checks++;
    if (PE_DIMEN !== 2'd0) begin
      errors++; $display("FAIL reset_pe_dimen: got %0d, expected 0", PE_DIMEN);
    end
  endtask

  task automatic test_idle_no_consume();
    SRC_VALID = 1'b1; SRC_DATA = 32'hDEADBEEF;
    #1;
    checks++;
    if (SRC_READY !== 1'b0 || PE_WRITE !== 1'b0) begin
      errors++;
      $display("FAIL idle_consume: got SRC_READY=%b PE_WRITE=%b, expected 0 0", SRC_READY, PE_WRITE);
    end
    checks++;
    if (PE_DATAIN !== 32'hDEADBEEF) begin
      errors++; $display("FAIL datain_passthru: got %h, expected deadbeef", PE_DATAIN);
    end
    SRC_VALID = 1'b0;
  endtask

  task automatic test_basic_latency();
    int lat, d0, w0;
    words_q = '{32'd2, 32'd3, 32'd4, 32'd5};
    exp_q.push_back(32'd23);
    d0 = done_cnt; w0 = write_cnt;
    do_op(2'd0, 0, 0, 0, 0, lat);
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL t1_latency: got %0d, expected 10", lat);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL t1_done_pulses: got %0d, expected 1", done_cnt - d0);
    end
    checks++;
    if (write_cnt - w0 !== 4) begin
      errors++; $display("FAIL t1_writes: got %0d, expected 4", write_cnt - w0);
    end
  endtask

  task automatic test_max_length();
    int lat, w0;
    for (int i = 0; i < 16; i++) words_q.push_back(DW'(i + 1));
    for (int i = 0; i < 16; i++) words_q.push_back(DW'(1));
    exp_q.push_back(32'd136);
    w0 = write_cnt;
    do_op(2'd3, 0, 0, 0, 0, lat);
    checks++;
    if (lat !== 52) begin
      errors++; $display("FAIL t2_latency: got %0d, expected 52", lat);
    end
    checks++;
    if (write_cnt - w0 !== 32) begin
      errors++; $display("FAIL t2_writes: got %0d, expected 32", write_cnt - w0);
    end
    checks++;
    if (PE_DIMEN !== 2'd3) begin
      errors++; $display("FAIL t2_dimen_latched: got %0d, expected 3", PE_DIMEN);
    end
    checks++;
    if (ERR !== 1'b0) begin
      errors++; $display("FAIL t2_err: got %b, expected 0", ERR);
    end
  endtask

  task automatic test_backpressure();
    int lat, w0;
    words_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4};
    exp_q.push_back(32'd30);
    w0 = write_cnt; stable_bad = 0;
    do_op(2'd1, 1, 5, 0, 0, lat);
    checks++;
    if (write_cnt - w0 !== 8) begin
      errors++; $display("FAIL t3_writes: got %0d, expected 8", write_cnt - w0);
    end
    checks++;
    if (stable_bad !== 1'b0) begin
      errors++; $display("FAIL t3_res_stable: got unstable=%b, expected 0", stable_bad);
    end
  endtask

  task automatic test_wrap_start_ignored();
    int lat, d0;
    words_q = '{32'h10000, 32'h10000, 32'h10000, 32'h10000};
    exp_q.push_back(32'd0);
    d0 = done_cnt;
    do_op(2'd0, 0, 0, 1, 0, lat);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL t4_done_pulses: got %0d, expected 1", done_cnt - d0);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL t4_idle_after: got BUSY=%b, expected 0", BUSY);
    end
  endtask

  task automatic test_abort_reset();
    int lat;
    words_q = '{32'd5, 32'd6, 32'd100, 32'd200};
    do_op(2'd0, 0, 0, 0, 3, lat);
    checks++;
    if (BUSY !== 1'b0 || SRC_READY !== 1'b0 || RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort_idle: got BUSY=%b SRC_READY=%b RES_VALID=%b, expected 0 0 0",
               BUSY, SRC_READY, RES_VALID);
    end
    words_q = '{32'd1, 32'd1, 32'd7, 32'd9};
    exp_q.push_back(32'd16);
    do_op(2'd0, 0, 0, 0, 0, lat);
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL t5_latency: got %0d, expected 10", lat);
    end
  endtask

  task automatic test_mac_done_check();
    int lat;
    force_bad = 1;
    words_q = '{32'd3, 32'd4, 32'd5, 32'd6};
    exp_q.push_back(32'd39);
    do_op(2'd0, 0, 0, 0, 0, lat);
    force_bad = 0;
`ifdef PE_SEQ_CHECK_EN
    checks++;
    if (ERR !== 1'b1) begin
      errors++; $display("FAIL t6_err_set: got %b, expected 1", ERR);
    end
    words_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    exp_q.push_back(32'd11);
    do_op(2'd0, 0, 0, 0, 0, lat);
    checks++;
    if (ERR !== 1'b1) begin
      errors++; $display("FAIL t6_err_sticky: got %b, expected 1", ERR);
    end
    apply_reset();
    checks++;
    if (ERR !== 1'b0) begin
      errors++; $display("FAIL t6_err_cleared: got %b, expected 0", ERR);
    end
`else
    checks++;
    if (ERR !== 1'b0) begin
      errors++; $display("FAIL t6_err_tied: got %b, expected 0", ERR);
    end
`endif
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; DIMEN = 2'd0; SRC_VALID = 1'b0;
    SRC_DATA = '0; RES_READY = 1'b0;
    test_reset();
    test_idle_no_consume();
    test_basic_latency();
    test_max_length();
    test_backpressure();
    test_wrap_start_ignored();
    test_abort_reset();
    test_mac_done_check();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL results_missing: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
